// File: rtl/byte_unaligner_pkg.sv
// Constants shared by the compressor-side byte packer and the decompressor-side unaligner.
// The helper converts a byte count into a bit shift amount.
package byte_unaligner_pkg;

  localparam int BYTE_W       = 8;
  localparam int IN_BYTES     = 32;
  localparam int MAX_RD_BYTES = 34;
  localparam int BUF_BYTES    = 64;
  localparam int FILL_W       = 7;
  localparam int BUF_W        = BUF_BYTES * BYTE_W;
  localparam int SHAMT_W      = FILL_W + 3;

  function automatic logic [SHAMT_W-1:0] bytesToBits(input logic [FILL_W-1:0] nBytes);
    return {nBytes, 3'b000};
  endfunction

endpackage

// File: rtl/byte_unaligner_register.sv
// Generic enabled register primitive with synchronous active-high reset.
module Register #(
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q_o <= RESET_VALUE;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/byte_unaligner.sv
// Turns a stream of dense 256-bit words into a byte-aligned 34-byte window for the
// token decoder, which consumes a variable number of bytes per cycle.
module byte_unaligner
  import byte_unaligner_pkg::*;
#(
  parameter int DATA_IN_WIDTH  = 256,
  parameter int DATA_OUT_WIDTH = 272,
  parameter int LEN_WIDTH      = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_IN_WIDTH-1:0]  data_in,
  input  logic                      rd_en,
  input  logic [LEN_WIDTH-1:0]      rd_len,
  output logic                      rd_ok,
  output logic [DATA_OUT_WIDTH-1:0] data_out,
  output logic [FILL_W-1:0]         fill,
  output logic                      err
);

  localparam int WIDE_W = BUF_W + DATA_IN_WIDTH;

  logic [BUF_W-1:0]  buf_q, buf_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              err_q;
  logic              errSet;
  logic              inFire;
  logic [FILL_W-1:0] consumed;
  logic [FILL_W-1:0] base;
  logic [BUF_W-1:0]  shifted;
  logic [BUF_W-1:0]  appended;

  assign in_ready = (fill_q <= FILL_W'(BUF_BYTES - IN_BYTES));
  assign rd_ok    = (rd_len <= LEN_WIDTH'(fill_q)) && (rd_len <= LEN_WIDTH'(MAX_RD_BYTES));
  assign inFire   = in_valid && in_ready;
  assign errSet   = rd_en && (rd_len > LEN_WIDTH'(MAX_RD_BYTES));

  // Consume first, then append behind the remaining bytes; the OR-merge is safe because
  // every byte at or above the fill level is held at zero.
  always_comb begin
    consumed = '0;
    if (rd_en && rd_ok) begin
      consumed = rd_len[FILL_W-1:0];
    end
    shifted  = buf_q >> bytesToBits(consumed);
    base     = fill_q - consumed;
    appended = BUF_W'({{BUF_W{1'b0}}, data_in} << bytesToBits(base));
    buf_d    = shifted;
    fill_d   = base;
    if (clear) begin
      buf_d  = '0;
      fill_d = '0;
    end else if (inFire) begin
      buf_d  = shifted | appended;
      fill_d = base + FILL_W'(IN_BYTES);
    end
  end

  Register #(.WIDTH(BUF_W)) bufReg (
    .clk_i(clk), .reset_i(reset), .en_i(1'b1), .d_i(buf_d), .q_o(buf_q)
  );

  Register #(.WIDTH(FILL_W)) fillReg (
    .clk_i(clk), .reset_i(reset), .en_i(1'b1), .d_i(fill_d), .q_o(fill_q)
  );

  // Sticky protocol error; clear deliberately does not reach it.
  Register #(.WIDTH(1)) errReg (
    .clk_i(clk), .reset_i(reset), .en_i(errSet), .d_i(1'b1), .q_o(err_q)
  );

  assign data_out = buf_q[DATA_OUT_WIDTH-1:0];
  assign fill     = fill_q;
  assign err      = err_q;

  // WIDE_W documents the intermediate width the append shift is evaluated at.
  if (WIDE_W < BUF_W + DATA_IN_WIDTH) begin : gWidthGuard
    $error("append shift width too narrow");
  end

endmodule

// File: tb/tb_byte_unaligner.sv
// Self-checking bench for byte_unaligner: directed boundary steps followed by a random
// run, compared every cycle against a byte-queue reference model via a scoreboard.
module tb_byte_unaligner;

  logic         clk = 1'b0;
  logic         reset, clear, in_valid, rd_en;
  logic [255:0] data_in;
  logic [7:0]   rd_len;
  logic         in_ready, rd_ok, err;
  logic [271:0] data_out;
  logic [6:0]   fill;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [271:0] win;
    logic [6:0]   fill;
    logic         err;
  } exp_t;

  logic [7:0] mq[$];
  logic       merr;
  exp_t       expQ[$];

  byte_unaligner dut (
    .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .rd_en(rd_en), .rd_len(rd_len), .rd_ok(rd_ok),
    .data_out(data_out), .fill(fill), .err(err)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mkWord(input logic [7:0] base);
    logic [255:0] w;
    for (int i = 0; i < 32; i++) w[i*8 +: 8] = 8'(base + 8'(i));
    return w;
  endfunction

  function automatic logic [271:0] modelWindow();
    logic [271:0] w;
    w = '0;
    for (int i = 0; i < 34; i++) begin
      if (i < mq.size()) w[i*8 +: 8] = mq[i];
    end
    return w;
  endfunction

  task automatic checkBits(input string tag, input logic [271:0] obs, input logic [271:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pops the expectation pushed when the stimulus for this edge was driven.
  task automatic checkOutput();
    exp_t e;
    checks++;
    assert (expQ.size() > 0) else begin
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=%0d expected=%0d", expQ.size(), 1);
    end
    if (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkBits("data_out", data_out, e.win);
      checkBits("fill", 272'(fill), 272'(e.fill));
      checkBits("err", 272'(err), 272'(e.err));
    end
  endtask

  // Drives one cycle of inputs, checks the combinational handshakes, advances the model,
  // then samples the registered outputs just after the edge.
  task automatic applyStimulus(input logic v, input logic [255:0] w, input logic re,
                               input logic [7:0] len, input logic clr);
    int   sz;
    logic [7:0] b;
    exp_t e;
    in_valid = v; data_in = w; rd_en = re; rd_len = len; clear = clr;
    #2;
    sz = mq.size();
    checkBits("in_ready", 272'(in_ready), 272'(sz <= 32));
    checkBits("rd_ok", 272'(rd_ok), 272'((int'(len) <= sz) && (len <= 8'd34)));
    if (clr) begin
      mq.delete();
    end else begin
      if (re && len > 8'd34) merr = 1'b1;
      if (re && len <= 8'd34 && int'(len) <= sz) begin
        for (int i = 0; i < int'(len); i++) b = mq.pop_front();
      end
      if (v && sz <= 32) begin
        for (int i = 0; i < 32; i++) mq.push_back(w[i*8 +: 8]);
      end
    end
    e.win = modelWindow(); e.fill = 7'(mq.size()); e.err = merr;
    expQ.push_back(e);
    @(posedge clk); #1;
    checkOutput();
  endtask

  task automatic doReset();
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; rd_en = 1'b0; rd_len = 8'd0; data_in = '0;
    @(posedge clk); #1;
    reset = 1'b0;
    mq.delete(); merr = 1'b0; expQ.delete();
    #1;
    checkBits("rst_fill", 272'(fill), 272'(0));
    checkBits("rst_data_out", data_out, 272'(0));
    checkBits("rst_err", 272'(err), 272'(0));
    checkBits("rst_in_ready", 272'(in_ready), 272'(1));
    checkBits("rst_rd_ok", 272'(rd_ok), 272'(1));
  endtask

  initial begin
    doReset();

    // Basic load, then simultaneous consume 5 and append.
    applyStimulus(1, mkWord(8'h00), 0, 8'd0, 0);
    checkBits("load_byte31", 272'(data_out[255:248]), 272'(8'h1F));
    checkBits("load_byte32_33", 272'(data_out[271:256]), 272'(0));
    applyStimulus(1, mkWord(8'h20), 1, 8'd5, 0);
    checkBits("merge_fill", 272'(fill), 272'(59));
    checkBits("merge_byte0", 272'(data_out[7:0]), 272'(8'h05));
    checkBits("merge_byte26", 272'(data_out[215:208]), 272'(8'h1F));
    checkBits("merge_byte27", 272'(data_out[223:216]), 272'(8'h20));

    // Fill to 64, stall input, consume 34, then accept again.
    applyStimulus(1, mkWord(8'h40), 1, 8'd27, 0);
    applyStimulus(1, mkWord(8'h40), 0, 8'd0, 0);
    checkBits("full_fill", 272'(fill), 272'(64));
    applyStimulus(1, mkWord(8'h60), 0, 8'd0, 0);
    applyStimulus(1, mkWord(8'h60), 1, 8'd34, 0);
    checkBits("drain_fill", 272'(fill), 272'(30));
    checkBits("drain_byte0", 272'(data_out[7:0]), 272'(8'h42));
    applyStimulus(1, mkWord(8'h60), 0, 8'd0, 0);
    checkBits("reaccept_fill", 272'(fill), 272'(62));

    // Short read retries silently; oversize read sets sticky error that survives clear.
    doReset();
    applyStimulus(1, mkWord(8'h00), 0, 8'd0, 0);
    applyStimulus(0, '0, 1, 8'd29, 0);
    applyStimulus(0, '0, 1, 8'd4, 0);
    checkBits("short_fill", 272'(fill), 272'(3));
    applyStimulus(0, '0, 1, 8'd35, 0);
    checkBits("err_set", 272'(err), 272'(1));
    applyStimulus(0, '0, 0, 8'd0, 1);
    applyStimulus(0, '0, 0, 8'd0, 0);
    checkBits("err_after_clear", 272'(err), 272'(1));
    doReset();

    // Clear with fill 40 and a word presented drops everything.
    applyStimulus(1, mkWord(8'h00), 0, 8'd0, 0);
    applyStimulus(1, mkWord(8'h20), 1, 8'd24, 0);
    checkBits("pre_clear_fill", 272'(fill), 272'(40));
    applyStimulus(1, mkWord(8'h80), 0, 8'd0, 1);
    checkBits("clear_fill", 272'(fill), 272'(0));
    checkBits("clear_data", data_out, 272'(0));

    // Random traffic against the byte-queue model.
    doReset();
    for (int n = 0; n < 10000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0,
                    {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
                    $urandom_range(0, 1) == 1, 8'($urandom_range(0, 34)),
                    $urandom_range(0, 499) == 0);
    end
    checkBits("scoreboard_drained", 272'(expQ.size()), 272'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
